// File: rtl/rsa_decrypt.sv
// rsa_decrypt: constant-time modular exponentiation M = C^d mod n.
// Right-to-left square-and-multiply. Every exponent bit costs a full MUL
// (W cycles), a full SQR (W cycles) and one NEXT cycle, whatever the
// operand values, so the latency never depends on the data.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   start  : request pulse, sampled only while idle
//   C,d,n  : ciphertext, private exponent, modulus (captured on accepted start)
//   M      : plaintext result, held until the next result is produced
//   finish : one-cycle pulse when M and err are valid
//   busy   : high while an operation is in progress
//   err    : operand error (n<2 or C>=n), valid with finish and held like M
module rsa_decrypt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] C,
  input  logic [W-1:0] d,
  input  logic [W-1:0] n,
  output logic [W-1:0] M,
  output logic         finish,
  output logic         busy,
  output logic         err
);

  // Two guard bits: 2P and P+a stay below 2n < 2^(W+1) without truncation.
  localparam int unsigned PW = W + 2;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL,
    S_SQR,
    S_NEXT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  p_q, p_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  m_q, m_d;
  logic          err_q, err_d;
  logic          finish_q, finish_d;
  logic          busy_q, busy_d;

  // Interleaved shift-add modular multiply step, multiplicand is always B.
  logic          mbit;
  logic [PW-1:0] n_ext;
  logic [PW-1:0] p_dbl;
  logic [PW-1:0] p_dbl_r;
  logic [PW-1:0] p_add;
  logic [PW-1:0] p_add_r;

  always_comb begin
    // MUL consumes bits of R (T = R*B), SQR consumes bits of B (B*B).
    mbit    = (state_q == S_MUL) ? r_q[j_q] : b_q[j_q];
    n_ext   = PW'(n_q);
    p_dbl   = PW'({p_q, 1'b0});
    p_dbl_r = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
    p_add   = p_dbl_r + (mbit ? PW'(b_q) : PW'(0));
    p_add_r = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    n_d      = n_q;
    r_d      = r_q;
    b_d      = b_q;
    t_d      = t_q;
    p_d      = p_q;
    j_d      = j_q;
    k_d      = k_q;
    m_d      = m_q;
    err_d    = err_q;
    finish_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d     = C;
          d_d     = d;
          n_d     = n;
          err_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if ((n_q < W'(2)) || (c_q >= n_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d     = W'(1);
          b_d     = c_q;
          k_d     = '0;
          j_d     = CW'(W - 1);
          p_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        p_d = W'(p_add_r);
        if (j_q == '0) begin
          t_d     = W'(p_add_r);
          p_d     = '0;
          j_d     = CW'(W - 1);
          state_d = S_SQR;
        end else begin
          j_d = j_q - CW'(1);
        end
      end
      S_SQR: begin
        // B is only overwritten on the last step, so every step sees the old B.
        p_d = W'(p_add_r);
        if (j_q == '0) begin
          b_d     = W'(p_add_r);
          p_d     = '0;
          j_d     = CW'(W - 1);
          state_d = S_NEXT;
        end else begin
          j_d = j_q - CW'(1);
        end
      end
      S_NEXT: begin
        if (d_q[k_q]) begin
          r_d = t_q;
        end
        if (k_q == CW'(W - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        m_d      = err_q ? '0 : r_q;
        finish_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      p_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      m_q      <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      n_q      <= n_d;
      r_q      <= r_d;
      b_q      <= b_d;
      t_q      <= t_d;
      p_q      <= p_d;
      j_q      <= j_d;
      k_q      <= k_d;
      m_q      <= m_d;
      err_q    <= err_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign M      = m_q;
  assign finish = finish_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// tb_rsa_decrypt: directed and randomized checks of rsa_decrypt against a
// plain-arithmetic modular exponentiation model.
module tb_rsa_decrypt;

  localparam int unsigned W   = 16;
  localparam int          LAT = W * (2 * W + 1) + 2;
  localparam int          ERR_LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] C;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic [W-1:0] M;
  logic         finish;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;

  rsa_decrypt #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .C      (C),
    .d      (d),
    .n      (n),
    .M      (M),
    .finish (finish),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: binary exponentiation with wide integers; 0 on invalid operands.
  function automatic logic [W-1:0] ref_modpow(input logic [W-1:0] c_v, input logic [W-1:0] d_v,
                                              input logic [W-1:0] n_v);
    longint unsigned r;
    longint unsigned b;
    longint unsigned e;
    longint unsigned m;
    m = longint'(n_v);
    if (n_v < 2 || c_v >= n_v) return '0;
    r = 1;
    b = longint'(c_v);
    e = longint'(d_v);
    while (e != 0) begin
      if (e % 2 == 1) r = (r * b) % m;
      b = (b * b) % m;
      e = e / 2;
    end
    return W'(r % m);
  endfunction

  // Starts an operation in the current cycle and waits for finish.
  // Returns in the cycle where finish is high, so a follow-up call is back-to-back.
  task automatic run_op(input string tag, input logic [W-1:0] c_v, input logic [W-1:0] d_v,
                        input logic [W-1:0] n_v, input logic [W-1:0] exp_m,
                        input logic exp_err, input int exp_lat, input bit inject);
    int           cnt;
    logic [W-1:0] m_prev;
    bit           m_moved;
    C       = c_v;
    d       = d_v;
    n       = n_v;
    start   = 1'b1;
    m_prev  = M;
    m_moved = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 0;
    while (finish !== 1'b1 && cnt < 2000) begin
      if (inject && cnt == 5) begin
        start = 1'b1;
        C     = ~c_v;
        d     = d_v ^ 16'h5a5a;
        n     = n_v ^ 16'h0f0f;
      end else if (inject && cnt == 6) begin
        start = 1'b0;
        C     = c_v;
        d     = d_v;
        n     = n_v;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (busy && M !== m_prev) m_moved = 1'b1;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_M"}, 32'(M), 32'(exp_m));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_M_hold"}, 32'(m_moved), 32'(0));
  endtask

  initial begin
    logic [W-1:0] c_r;
    logic [W-1:0] d_r;
    logic [W-1:0] n_r;
    int           pulses;

    rst   = 1'b1;
    start = 1'b0;
    C     = '0;
    d     = '0;
    n     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_M", 32'(M), 32'(0));
    check("reset_finish", 32'(finish), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Worked example: 3156^1373 mod 3551.
    run_op("rsa3551", 16'd3156, 16'd1373, 16'd3551, 16'd1256, 1'b0, LAT, 1'b0);
    @(posedge clk);
    #1;
    check("finish_one_cycle", 32'(finish), 32'(0));
    check("busy_after", 32'(busy), 32'(0));

    // Back-to-back runs, including d=0 and d=1.
    run_op("n33_d7", 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, LAT, 1'b0);
    run_op("n33_d0", 16'd31, 16'd0, 16'd33, 16'd1, 1'b0, LAT, 1'b0);
    run_op("n33_d1", 16'd20, 16'd1, 16'd33, 16'd20, 1'b0, LAT, 1'b0);
    run_op("c0", 16'd0, 16'd9, 16'd33, 16'd0, 1'b0, LAT, 1'b0);

    // Operand errors, then a valid run clears err.
    run_op("err_n1", 16'd0, 16'd5, 16'd1, 16'd0, 1'b1, ERR_LAT, 1'b0);
    run_op("err_c_eq_n", 16'd3551, 16'd1373, 16'd3551, 16'd0, 1'b1, ERR_LAT, 1'b0);
    run_op("err_clear", 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, LAT, 1'b0);

    // Reset mid-operation aborts without a finish pulse.
    C     = 16'd3156;
    d     = 16'd1373;
    n     = 16'd3551;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_M", 32'(M), 32'(0));
    check("abort_finish", 32'(finish), 32'(0));
    pulses = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (finish) pulses++;
    end
    check("abort_no_finish", 32'(pulses), 32'(0));
    run_op("after_abort", 16'd3156, 16'd1373, 16'd3551, 16'd1256, 1'b0, LAT, 1'b0);

    // start while busy must be ignored.
    run_op("ignore_start", 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, LAT, 1'b1);

    // Randomized operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      n_r = W'($urandom_range(65535, 2));
      c_r = W'($urandom % 32'(n_r));
      d_r = W'($urandom);
      run_op($sformatf("rand%0d", i), c_r, d_r, n_r, ref_modpow(c_r, d_r, n_r), 1'b0, LAT, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
REQ-001 SHALL have parameter W, default 16, giving the operand width of C, d, n and M.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have port C, input, W bits: ciphertext, captured on an accepted start.
REQ-006 SHALL have port d, input, W bits: private exponent, captured on an accepted start.
REQ-007 SHALL have port n, input, W bits: modulus, captured on an accepted start.
REQ-008 SHALL have port M, output, W bits: plaintext result, C^d mod n, held until the next accepted start.
REQ-009 SHALL have port finish, output, 1 bit: one-cycle pulse when M and err are valid.
REQ-010 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-011 SHALL have port err, output, 1 bit: operand error flag, valid with finish and held like M.

Function
REQ-012 SHALL implement the FSM states IDLE, INIT, MUL, SQR, NEXT and DONE.
REQ-013 SHALL, in IDLE with start=1, latch C, d and n, clear err and go to INIT on that edge; start while busy is ignored with no effect.
REQ-014 SHALL, in INIT (1 cycle), go to DONE with M=0 and err=1 if n<2 or C>=n; otherwise it sets R=1, B=C, bit index k=0 and goes to MUL.
REQ-015 SHALL compute MUL as T=R*B mod n by the interleaved shift-add method, MSB first: 1 multiplier bit per cycle, W cycles, with P=2P then subtract n if P>=n, then P=P+a then subtract n if P>=n; intermediates are W+2 bits wide and never truncated.
REQ-016 SHALL compute SQR as B=B*B mod n by the same method in W cycles, on the B value held before this bit's update.
REQ-017 SHALL, in NEXT (1 cycle), set R=T if d[k]=1 and keep R otherwise, then increment k; after k=W-1 it goes to DONE, otherwise to MUL.
REQ-018 SHALL always perform MUL and SQR for every exponent bit, including leading zeros, so that latency is independent of d, C and n (constant time).
REQ-019 SHALL, in DONE (1 cycle), drive M=R (or 0 on error) and finish=1, then go to IDLE.
REQ-020 SHALL give a valid-operand latency of W*(2W+1)+2 cycles from the start-sampling edge to the cycle finish is high: 530 cycles for W=16.
REQ-021 SHALL give an error latency of 2 cycles from the start-sampling edge to finish.
REQ-022 SHALL produce d=0 -> M=1, d=1 -> M=C and C=0 (with d>0) -> M=0, with no special-case logic needed.
REQ-023 SHALL accept start in the cycle immediately after DONE, back-to-back with no gap.
REQ-024 SHALL keep M and err stable, and not change them, while busy is high.

Reset
REQ-025 SHALL, on a clock edge with rst=1, go to IDLE with M=0, finish=0, busy=0, err=0, R=0, B=0, T=0 and k=0.
REQ-026 SHALL give rst priority over start and over any state, including mid-MUL and mid-SQR; no finish is produced for an aborted operation.

Verification
REQ-027 SHALL pass this scenario: n=3551 (67*53), d=1373, C=3156, pulse start -> finish exactly 530 cycles later, M=1256, err=0.
REQ-028 SHALL pass this scenario: n=33, d=7, C=31 -> M=4; immediately restart with d=0 -> M=1; then with d=1, C=20 -> M=20.
REQ-029 SHALL pass these scenarios: n=1, or n=3551 with C=3551 -> finish 2 cycles after start, err=1, M=0; next valid run clears err.
REQ-030 SHALL pass this scenario: assert rst at cycle 200 of a run -> next edge busy=0, M=0, finish never pulses; a new start then completes correctly.
REQ-031 SHALL pass this scenario: start pulsed again with different C/d/n while busy -> ignored; result matches the first operands and latency stays 530.
REQ-032 SHALL pass a randomized check: 200 random operands with 2<=n<2^16 and C<n, compared against a reference C^d mod n model; finish always lands at exactly 530 cycles.
